// File: rtl/enemy_fire_scheduler.sv
// Picks which enemy fires next: waits a jittered cooldown counted in frame ticks,
// then does a round-robin search and holds a request until the bullet engine accepts it.
module enemy_fire_scheduler #(
  parameter int N_INIMIGOS  = 5,
  parameter int BASE_TICKS  = 30,
  parameter int JITTER_BITS = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  reset_n,
  input  logic                  pausa,
  input  logic                  tick,
  input  logic [N_INIMIGOS-1:0] inimigo_vivo_array,
  input  logic [N_INIMIGOS-1:0] bala_livre,
  output logic                  fire_req,
  output logic [2:0]            fire_idx,
  input  logic                  fire_ack,
  output logic [7:0]            disparos,
  output logic                  todos_mortos
);

  typedef enum logic [1:0] {ESPERA, SELECAO, PEDIDO} state_t;

  state_t     state, state_n;
  logic [7:0] counter, counter_n;
  logic [2:0] ptr, ptr_n;
  logic [2:0] fire_idx_n;
  logic [7:0] disparos_n;
  logic [7:0] lfsr;

  logic [7:0] vivo8, livre8, elegivel8;
  logic       hit;
  logic [2:0] cand, j;
  logic [8:0] soma;
  logic [7:0] cooldown;

  // Pad to 8 bits so a 3-bit index always selects within range.
  assign vivo8        = 8'(inimigo_vivo_array);
  assign livre8       = 8'(bala_livre);
  assign elegivel8    = vivo8 & livre8;
  assign todos_mortos = ~|inimigo_vivo_array;
  assign fire_req     = (state == PEDIDO) && !pausa && !todos_mortos;

  assign soma     = 9'(BASE_TICKS) + 9'(lfsr[JITTER_BITS-1:0]);
  assign cooldown = soma[8] ? 8'hFF : soma[7:0];

  // Walk from the farthest candidate back to ptr+1 so the nearest eligible one wins.
  always_comb begin
    hit  = 1'b0;
    cand = '0;
    j    = '0;
    for (int k = N_INIMIGOS; k >= 1; k--) begin
      j = 3'((int'(ptr) + k) % N_INIMIGOS);
      if (elegivel8[j]) begin
        hit  = 1'b1;
        cand = j;
      end
    end
  end

  always_comb begin
    state_n    = state;
    counter_n  = counter;
    ptr_n      = ptr;
    fire_idx_n = fire_idx;
    disparos_n = disparos;
    if (!pausa) begin
      if (todos_mortos && state != ESPERA) begin
        state_n   = ESPERA;
        counter_n = 8'(BASE_TICKS);
      end else begin
        unique case (state)
          ESPERA: begin
            if (counter == 8'd0) state_n = SELECAO;
            else if (tick)       counter_n = counter - 8'd1;
          end
          SELECAO: begin
            if (hit) begin
              fire_idx_n = cand;
              ptr_n      = cand;
              state_n    = PEDIDO;
            end
          end
          PEDIDO: begin
            if (fire_ack) begin
              if (disparos != 8'hFF) disparos_n = disparos + 8'd1;
              counter_n = cooldown;
              state_n   = ESPERA;
            end else if (!elegivel8[fire_idx]) begin
              state_n = SELECAO;
            end
          end
          default: state_n = ESPERA;
        endcase
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ESPERA;
      counter  <= 8'(BASE_TICKS);
      ptr      <= 3'(N_INIMIGOS - 1);
      fire_idx <= '0;
      disparos <= '0;
    end else begin
      state    <= state_n;
      counter  <= counter_n;
      ptr      <= ptr_n;
      fire_idx <= fire_idx_n;
      disparos <= disparos_n;
    end
  end

  // Jitter source keeps running through pauses so resumed cooldowns differ.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) lfsr <= 8'hA5;
    else          lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// Bench for enemy_fire_scheduler: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of the scheduling rules.
module tb_enemy_fire_scheduler;

  localparam int N    = 5;
  localparam int BASE = 4;
  localparam int JB   = 4;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n  = 1'b0;
  logic       pausa    = 1'b0;
  logic       tick     = 1'b0;
  logic       fire_ack = 1'b0;
  logic [4:0] vivo     = 5'h1F;
  logic [4:0] livre    = 5'h1F;
  logic       fire_req;
  logic [2:0] fire_idx;
  logic [7:0] disparos;
  logic       todos_mortos;

  int vectors     = 0;
  int miscompares = 0;

  int         m_fase;
  int         m_cnt;
  int         m_ptr;
  int         m_idx;
  int         m_shots;
  logic [7:0] m_lfsr;

  enemy_fire_scheduler #(.N_INIMIGOS(N), .BASE_TICKS(BASE), .JITTER_BITS(JB)) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .pausa(pausa), .tick(tick),
    .inimigo_vivo_array(vivo), .bala_livre(livre), .fire_req(fire_req),
    .fire_idx(fire_idx), .fire_ack(fire_ack), .disparos(disparos),
    .todos_mortos(todos_mortos)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task verifica(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task modelo_reset;
    m_fase  = 0;
    m_cnt   = BASE;
    m_ptr   = N - 1;
    m_idx   = 0;
    m_shots = 0;
    m_lfsr  = 8'hA5;
  endtask

  // fase: 0 = waiting cooldown, 1 = searching, 2 = requesting
  task modelo_passo(input logic p, input logic t, input logic [4:0] v,
                    input logic [4:0] l, input logic a);
    int fb, jit, pos;
    bit achou;
    jit = int'(m_lfsr) % (1 << JB);
    fb  = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
    m_lfsr = 8'(((int'(m_lfsr) * 2) + fb) % 256);
    if (!p) begin
      if (v == 5'd0 && m_fase != 0) begin
        m_fase = 0;
        m_cnt  = BASE;
      end else if (m_fase == 0) begin
        if (m_cnt == 0) m_fase = 1;
        else if (t)     m_cnt  = m_cnt - 1;
      end else if (m_fase == 1) begin
        achou = 1'b0;
        for (int k = 1; k <= N; k++) begin
          pos = (m_ptr + k) % N;
          if (!achou && v[pos] && l[pos]) begin
            achou  = 1'b1;
            m_idx  = pos;
            m_ptr  = pos;
            m_fase = 2;
          end
        end
      end else begin
        if (a) begin
          m_shots = (m_shots < 255) ? m_shots + 1 : 255;
          m_cnt   = (BASE + jit > 255) ? 255 : BASE + jit;
          m_fase  = 0;
        end else if (!(v[m_idx] && l[m_idx])) begin
          m_fase = 1;
        end
      end
    end
  endtask

  task passo(input logic p, input logic t, input logic [4:0] v,
             input logic [4:0] l, input logic a);
    pausa    = p;
    tick     = t;
    vivo     = v;
    livre    = l;
    fire_ack = a;
    #1;
    verifica("fire_req", {7'b0, fire_req}, {7'b0, (m_fase == 2 && !p && v != 5'd0)});
    verifica("fire_idx", {5'b0, fire_idx}, 8'(m_idx));
    verifica("disparos", disparos, 8'(m_shots));
    verifica("todos_mortos", {7'b0, todos_mortos}, {7'b0, (v == 5'd0)});
    @(posedge CLOCK_50);
    modelo_passo(p, t, v, l, a);
    @(negedge CLOCK_50);
  endtask

  task espera_pedido(input logic [4:0] v, input logic [4:0] l);
    for (int i = 0; i < 300 && m_fase != 2; i++) passo(1'b0, 1'b1, v, l, 1'b0);
    if (m_fase != 2) verifica("timeout_pedido", 8'd0, 8'd1);
  endtask

  task dispara(input logic [4:0] v, input logic [4:0] l, input int exp, input string tag);
    espera_pedido(v, l);
    #1;
    verifica(tag, {5'b0, fire_idx}, 8'(exp));
    passo(1'b0, 1'b1, v, l, 1'b1);
  endtask

  initial begin
    int ticks;
    int antes;
    modelo_reset();
    repeat (2) @(negedge CLOCK_50);
    verifica("reset_req", {7'b0, fire_req}, 8'd0);
    verifica("reset_idx", {5'b0, fire_idx}, 8'd0);
    verifica("reset_disparos", disparos, 8'd0);
    reset_n = 1'b1;

    ticks = 0;
    for (int c = 0; c < 80 && m_fase != 2; c++) begin
      passo(1'b0, (c % 10 == 9), 5'h1F, 5'h1F, 1'b0);
      if (c % 10 == 9) ticks++;
    end
    #1;
    verifica("ticks_ate_req", 8'(ticks), 8'd4);
    verifica("primeiro_req", {7'b0, fire_req}, 8'd1);
    verifica("primeiro_idx", {5'b0, fire_idx}, 8'd0);
    passo(1'b0, 1'b0, 5'h1F, 5'h1F, 1'b1);
    #1;
    verifica("primeiro_disparo", disparos, 8'd1);

    dispara(5'h1F, 5'h1F, 1, "seq_1");
    dispara(5'h1F, 5'h1F, 2, "seq_2");
    dispara(5'h1F, 5'h1F, 3, "seq_3");
    dispara(5'h1F, 5'h1F, 4, "seq_4");
    dispara(5'h1F, 5'h1F, 0, "seq_0");

    dispara(5'b10100, 5'h1F, 2, "rr_2");
    dispara(5'b10100, 5'h1F, 4, "rr_4");
    dispara(5'b10100, 5'h1F, 2, "rr_2b");

    espera_pedido(5'b01000, 5'h1F);
    #1;
    verifica("pedido_idx3", {5'b0, fire_idx}, 8'd3);
    passo(1'b0, 1'b1, 5'b10000, 5'h1F, 1'b0);
    #1;
    verifica("retirada_req", {7'b0, fire_req}, 8'd0);
    dispara(5'b10000, 5'h1F, 4, "reselecao_4");
    espera_pedido(5'b01000, 5'h1F);
    antes = int'(disparos);
    passo(1'b0, 1'b1, 5'b10000, 5'h1F, 1'b1);
    #1;
    verifica("ack_vence_queda", disparos, 8'(antes + 1));

    repeat (15) passo(1'b1, 1'b1, 5'h1F, 5'h1F, 1'b0);
    espera_pedido(5'h1F, 5'h1F);
    antes = int'(disparos);
    repeat (3) passo(1'b1, 1'b1, 5'h1F, 5'h1F, 1'b1);
    #1;
    verifica("ack_em_pausa", disparos, 8'(antes));
    passo(1'b0, 1'b1, 5'h1F, 5'h1F, 1'b1);

    for (int c = 0; c < 500; c++)
      passo($urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));

    espera_pedido(5'h1F, 5'h1F);
    #3;
    reset_n = 1'b0;
    #1;
    verifica("reset_async_req", {7'b0, fire_req}, 8'd0);
    verifica("reset_async_disparos", disparos, 8'd0);
    modelo_reset();
    @(negedge CLOCK_50);
    reset_n = 1'b1;

    for (int c = 0; c < 40; c++) passo(1'b0, 1'b1, 5'd0, 5'h1F, 1'($urandom_range(0, 1)));
    for (int c = 0; c < 60; c++) passo(1'b0, 1'b1, 5'b00110, 5'h1F, 1'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/enemy_fire_scheduler.md
ENEMY_FIRE_SCHEDULER -- requirements
Module: enemy_fire_scheduler

Interface
REQ-001 SHALL have parameter N_INIMIGOS, default 5, number of enemy firing sources.
REQ-002 SHALL have parameter BASE_TICKS, default 30, minimum ticks between enemy shots.
REQ-003 SHALL have parameter JITTER_BITS, default 4, number of LFSR bits added to the cooldown.
REQ-004 SHALL have port CLOCK_50  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port pausa  in  1  freezes the scheduler while 1.
REQ-007 SHALL have port tick  in  1  one-cycle frame pulse used as the cooldown time base.
REQ-008 SHALL have port inimigo_vivo_array  in  N_INIMIGOS  bit i = enemy i alive.
REQ-009 SHALL have port bala_livre  in  N_INIMIGOS  bit i = enemy i bullet slot idle.
REQ-010 SHALL have port fire_req  out  1  request to launch a bullet from enemy fire_idx.
REQ-011 SHALL have port fire_idx  out  3  index of the selected enemy, 0..N_INIMIGOS-1.
REQ-012 SHALL have port fire_ack  in  1  one-cycle acceptance from the bullet engine.
REQ-013 SHALL have port disparos  out  8  count of acknowledged shots, saturating.
REQ-014 SHALL have port todos_mortos  out  1  high when inimigo_vivo_array == 0.

Function
REQ-015 SHALL implement FSM states ESPERA, SELECAO, PEDIDO.
REQ-016 SHALL, in ESPERA, decrement an 8-bit cooldown counter on each cycle with tick=1 and pausa=0; at counter==0 the next cycle enters SELECAO.
REQ-017 SHALL, in SELECAO, search round-robin from ptr+1 (wrapping at N_INIMIGOS-1 to 0) for the first i with inimigo_vivo_array[i] & bala_livre[i], in one cycle.
REQ-018 SHALL, on a SELECAO hit, register fire_idx=i, set ptr=i, and enter PEDIDO; with no candidate, remain in SELECAO and retry every cycle.
REQ-019 SHALL assert fire_req=1 exactly while in PEDIDO with pausa=0; fire_idx stable throughout PEDIDO.
REQ-020 SHALL, on fire_ack=1 in PEDIDO, deassert fire_req next cycle, increment disparos (saturate at 255), load cooldown = BASE_TICKS + lfsr[JITTER_BITS-1:0], and enter ESPERA.
REQ-021 SHALL, if inimigo_vivo_array[fire_idx] or bala_livre[fire_idx] falls to 0 in PEDIDO without fire_ack in the same cycle, withdraw fire_req next cycle and return to SELECAO; fire_ack in the same cycle wins.
REQ-022 SHALL ignore fire_ack outside PEDIDO or while pausa=1.
REQ-023 SHALL, while pausa=1, hold state, counter, ptr, fire_idx and disparos unchanged and drive fire_req=0; pausa overrides a coincident tick.
REQ-024 SHALL drive todos_mortos combinationally; while 1, fire_req=0 and an FSM outside ESPERA moves to ESPERA with counter=BASE_TICKS.
REQ-025 SHALL run an 8-bit Fibonacci LFSR, taps 8,6,5,4, advancing every cycle regardless of pausa.
REQ-026 SHALL compute the cooldown sum in 9 bits and clamp to 255.

Reset
REQ-027 SHALL, on reset_n=0, immediately set state=ESPERA, counter=BASE_TICKS, ptr=N_INIMIGOS-1, fire_idx=0, fire_req=0, disparos=0, lfsr=8'hA5.
REQ-028 SHALL abandon any pending request on reset mid-PEDIDO, with no ack counted.
REQ-029 SHALL resume on the first rising edge after reset_n returns to 1.

Verification
REQ-030 SHALL cover: BASE_TICKS=4, all alive/free, ticks every 10 cycles -> fire_req with fire_idx=0 after the 4th tick plus 1 cycle; ack -> disparos=1.
REQ-031 SHALL cover: successive acks with all eligible -> fire_idx sequence 0,1,2,3,4,0.
REQ-032 SHALL cover: vivo=5'b10100, ptr=2 -> next fire_idx=4, then 2.
REQ-033 SHALL cover: in PEDIDO for idx 3, vivo[3] drops without ack -> fire_req=0 next cycle, reselect; same-cycle ack -> shot counted.
REQ-034 SHALL cover: pausa=1 during ESPERA with ticks -> counter frozen; pausa=1 in PEDIDO -> fire_req=0, and ack ignored.
REQ-035 SHALL cover: reset_n pulsed low in PEDIDO -> fire_req=0 asynchronously, disparos=0; vivo=0 -> todos_mortos=1, no requests.
